// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU controller.
// Control word layout and decode helpers used by the FSM and decoder.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_EXEC   = 3'd5,
    S_WR_REG = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  localparam logic [3:0] VSEL_NONE  = 4'b0000;
  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [3:0] vsel;
    logic       write;
    logic       illegal;
  } ctrl_t;

  // S_WAIT here means the fields name no supported instruction.
  function automatic state_e decode_next(
    input logic [2:0] opc,
    input logic [1:0] op
  );
    state_e nxt;
    nxt = S_WAIT;
    if (opc == OPC_MOV && op == OP_MOV_IMM)
      nxt = S_WR_IMM;
    else if (opc == OPC_MOV && op == OP_MOV_REG)
      nxt = S_GET_B;
    else if (opc == OPC_ALU && op == OP_MVN)
      nxt = S_GET_B;
    else if (opc == OPC_ALU)
      nxt = S_GET_A;
    return nxt;
  endfunction

  function automatic logic is_unary(
    input logic [2:0] opc,
    input logic [1:0] op
  );
    return (opc == OPC_MOV && op == OP_MOV_REG) ||
           (opc == OPC_ALU && op == OP_MVN);
  endfunction

  function automatic logic is_cmp(
    input logic [2:0] opc,
    input logic [1:0] op
  );
    return opc == OPC_ALU && op == OP_CMP;
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Controller <-> decoder/datapath bundle.
// master = controller, slave = decoder and datapath side.
interface cpu_ctrl_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [3:0] vsel;
  logic       write;
  logic       illegal;

  modport master (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc,
    output loads, asel, bsel, vsel,
    output write, illegal
  );

  modport slave (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc,
    input  loads, asel, bsel, vsel,
    input  write, illegal
  );
endinterface

// File: rtl/cpu_ctrl_outdec.sv
// Moore control-word decoder: state plus latched fields
// map to the datapath control word.
module cpu_ctrl_outdec
  import cpu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] ir_opcode,
  input  logic [1:0] ir_op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_WAIT: ctrl.w = 1'b1;
      S_DECODE:
        ctrl.illegal =
          decode_next(ir_opcode, ir_op) == S_WAIT;
      S_WR_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_IMM8;
        ctrl.write = 1'b1;
      end
      S_GET_A: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
      end
      S_EXEC: begin
        ctrl.asel = is_unary(ir_opcode, ir_op);
        if (is_cmp(ir_opcode, ir_op))
          ctrl.loads = 1'b1;
        else
          ctrl.loadc = 1'b1;
      end
      S_WR_REG: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle controller: one instruction per start request,
// state register and field latch; outputs come from outdec.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  cpu_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic [2:0] ir_opcode_q, ir_opcode_d;
  logic [1:0] ir_op_q, ir_op_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d     = state_q;
    ir_opcode_d = ir_opcode_q;
    ir_op_d     = ir_op_q;
    unique case (state_q)
      S_WAIT:
        if (bus.s) begin
          state_d     = S_DECODE;
          ir_opcode_d = bus.opcode;
          ir_op_d     = bus.op;
        end
      S_DECODE:
        state_d = decode_next(ir_opcode_q, ir_op_q);
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:
        state_d = is_cmp(ir_opcode_q, ir_op_q)
                ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_WAIT;
      ir_opcode_q <= '0;
      ir_op_q     <= '0;
    end else begin
      state_q     <= state_d;
      ir_opcode_q <= ir_opcode_d;
      ir_op_q     <= ir_op_d;
    end
  end

  cpu_ctrl_outdec u_outdec (
    .state     (state_q),
    .ir_opcode (ir_opcode_q),
    .ir_op     (ir_op_q),
    .ctrl      (ctrl)
  );

  assign bus.w       = ctrl.w;
  assign bus.nsel    = ctrl.nsel;
  assign bus.loada   = ctrl.loada;
  assign bus.loadb   = ctrl.loadb;
  assign bus.loadc   = ctrl.loadc;
  assign bus.loads   = ctrl.loads;
  assign bus.asel    = ctrl.asel;
  assign bus.bsel    = ctrl.bsel;
  assign bus.vsel    = ctrl.vsel;
  assign bus.write   = ctrl.write;
  assign bus.illegal = ctrl.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Random + directed bench for cpu_ctrl_fsm against a
// per-instruction control-word sequence model.
module tb_cpu_ctrl_fsm;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cpu_ctrl_if bus();

  cpu_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // {w,nsel,loada,loadb,loadc,loads,asel,bsel,vsel,write,illegal}
  localparam logic [15:0] IDLE = 16'h8000;
  logic [15:0] exp_q[$];

  wire [15:0] word = {
    bus.w, bus.nsel, bus.loada, bus.loadb,
    bus.loadc, bus.loads, bus.asel, bus.bsel,
    bus.vsel, bus.write, bus.illegal
  };
  wire [2:0] n_strobe = 3'(bus.loada) + 3'(bus.loadb)
                      + 3'(bus.loadc) + 3'(bus.loads)
                      + 3'(bus.write);

  function automatic logic [15:0] cw(
    input logic [2:0] nsel,
    input logic [3:0] ld,
    input logic       asel,
    input logic [3:0] vsel,
    input logic       wr,
    input logic       ill
  );
    return {1'b0, nsel, ld, asel, 1'b0, vsel, wr, ill};
  endfunction

  function automatic logic [15:0] cur_exp();
    return exp_q.size() != 0 ? exp_q[0] : IDLE;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  // Expected per-cycle words from the decode cycle onwards.
  task automatic push_seq(
    input logic [2:0] opc,
    input logic [1:0] op
  );
    logic [15:0] ld_a, ld_b, wr_rd;
    ld_a  = cw(3'b100, 4'b1000, 0, 4'b0000, 0, 0);
    ld_b  = cw(3'b001, 4'b0100, 0, 4'b0000, 0, 0);
    wr_rd = cw(3'b010, 4'b0000, 0, 4'b0001, 1, 0);
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(16'h0000);
      exp_q.push_back(cw(3'b100, 0, 0, 4'b0100, 1, 0));
    end else if ((opc == 3'b110 && op == 2'b00) ||
                 (opc == 3'b101 && op == 2'b11)) begin
      exp_q.push_back(16'h0000);
      exp_q.push_back(ld_b);
      exp_q.push_back(cw(0, 4'b0010, 1, 0, 0, 0));
      exp_q.push_back(wr_rd);
    end else if (opc == 3'b101 && op == 2'b01) begin
      exp_q.push_back(16'h0000);
      exp_q.push_back(ld_a);
      exp_q.push_back(ld_b);
      exp_q.push_back(cw(0, 4'b0001, 0, 0, 0, 0));
    end else if (opc == 3'b101) begin
      exp_q.push_back(16'h0000);
      exp_q.push_back(ld_a);
      exp_q.push_back(ld_b);
      exp_q.push_back(cw(0, 4'b0010, 0, 0, 0, 0));
      exp_q.push_back(wr_rd);
    end else begin
      exp_q.push_back(cw(0, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic step(
    input logic       s_i,
    input logic [2:0] opc_i,
    input logic [1:0] op_i,
    input bit         rst_i
  );
    @(negedge clk);
    bus.s      = s_i;
    bus.opcode = opc_i;
    bus.op     = op_i;
    if (rst_i) begin
      reset_n = 1'b0;
      #1;
      chk("rst_async", word, IDLE);
      exp_q.delete();
      #1 reset_n = 1'b1;
    end
    @(posedge clk);
    if (exp_q.size() == 0) begin
      if (s_i) push_seq(opc_i, op_i);
    end else begin
      void'(exp_q.pop_front());
    end
    #1;
    chk("cycle", word, cur_exp());
    chk("strobe_excl", 16'(n_strobe <= 3'd1), 16'd1);
  endtask

  logic [2:0] r_opc;
  logic [1:0] r_op;
  logic       r_s;
  bit         r_rst;

  initial begin
    reset_n    = 1'b0;
    bus.s      = 1'b0;
    bus.opcode = '0;
    bus.op     = '0;
    #2;
    chk("reset", word, IDLE);
    @(negedge clk);
    reset_n = 1'b1;

    // MOV imm; opcode changes after the sampling edge
    step(1, 3'b110, 2'b10, 0);
    repeat (3) step(0, 3'b101, 2'b00, 0);
    // ADD
    step(1, 3'b101, 2'b00, 0);
    repeat (6) step(0, 3'b000, 2'b00, 0);
    // CMP then MVN with s held high
    step(1, 3'b101, 2'b01, 0);
    repeat (5) step(1, 3'b101, 2'b11, 0);
    repeat (5) step(0, 3'b101, 2'b11, 0);
    // illegal fields
    step(1, 3'b111, 2'($urandom), 0);
    repeat (2) step(0, 3'b000, 2'b00, 0);
    step(1, 3'b110, 2'b01, 0);
    repeat (2) step(0, 3'b000, 2'b00, 0);
    // AND with a stray start pulse during S_GET_B
    step(1, 3'b101, 2'b10, 0);
    repeat (2) step(0, 3'b000, 2'b00, 0);
    step(1, 3'b110, 2'b10, 0);
    repeat (6) step(0, 3'b000, 2'b00, 0);
    // reset while writing Rd
    step(1, 3'b101, 2'b00, 0);
    repeat (4) step(0, 3'b000, 2'b00, 0);
    chk("wr_reg_write", 16'(bus.write), 16'd1);
    step(0, 3'b000, 2'b00, 1);
    repeat (3) step(0, 3'b000, 2'b00, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 5))
          0: begin r_opc = 3'b110; r_op = 2'b10; end
          1: begin r_opc = 3'b110; r_op = 2'b00; end
          default: begin
            r_opc = 3'b101;
            r_op  = 2'($urandom);
          end
        endcase
      end else begin
        r_opc = 3'($urandom);
        r_op  = 2'($urandom);
      end
      if ((i % 500) < 120)
        r_s = 1'b1;
      else
        r_s = 1'($urandom_range(0, 2) == 0);
      r_rst = cur_exp()[1] &&
              $urandom_range(0, 19) == 0;
      step(r_s, r_opc, r_op, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multicycle controller that sequences the simple-CPU datapath (register file, A/B/C registers, shifter, ALU, status register) for one instruction per start request.
- Consumes opcode/op fields from the instruction decoder.
- Drives the register-file select (nsel), the load enables, the mux selects and the write strobe.
- Sits between the instruction register/decoder and the datapath; asserts w while idle.

Parameters:
- none; all state and select encodings are fixed constants in cpu_ctrl_pkg.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- s  input  1  start; sampled only in S_WAIT
- opcode  input  3  decoder opcode field (110=MOV, 101=ALU)
- op  input  2  decoder op field
- w  output  1  1 = idle in S_WAIT, ready for s
- nsel  output  3  one-hot register select: [2]=Rn, [1]=Rd, [0]=Rm; 000 when no access
- loada  output  1  load A register
- loadb  output  1  load B register
- loadc  output  1  load C register
- loads  output  1  load status flags
- asel  output  1  1 = ALU A input forced to 0
- bsel  output  1  1 = ALU B input from sximm5; always 0 in this instruction set
- vsel  output  4  one-hot writeback select: [3]=mdata, [2]=sximm8, [1]=PC, [0]=C
- write  output  1  register-file write strobe
- illegal  output  1  one-cycle pulse on an unsupported opcode/op

Behaviour:
- Moore outputs are decoded from the state register and the latched instruction fields. Every signal not listed for a state is 0.
- On reset (asynchronous, any state): state=S_WAIT, latched fields=0. Outputs immediately become w=1 with all others 0, so write drops without waiting for a clock.
- Latching: in S_WAIT with s=1, opcode/op are captured into ir_opcode/ir_op on the same edge that enters S_DECODE. The inputs may change afterwards without effect.
- S_WAIT: w=1.
  - s=1 -> S_DECODE; else stay.
- S_DECODE: no datapath action. Next state by latched fields:
  - 110/10 (MOV Rn,#imm8) -> S_WR_IMM
  - 110/00 (MOV Rd,Rm) and 101/11 (MVN) -> S_GET_B
  - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> S_GET_A
  - anything else -> S_WAIT with illegal=1 during this S_DECODE cycle
- S_WR_IMM: nsel=100, vsel=0100, write=1 -> S_WAIT.
- S_GET_A: nsel=100, loada=1 -> S_GET_B.
- S_GET_B: nsel=001, loadb=1 -> S_EXEC.
- S_EXEC: asel=1 for MOV-reg and MVN, else 0; bsel=0.
  - CMP: loads=1, loadc=0 -> S_WAIT.
  - Others: loadc=1 -> S_WR_REG.
- S_WR_REG: nsel=010, vsel=0001, write=1 -> S_WAIT.
- Latency in clocks from the s-sampling edge until w=1 again:
  - MOV imm: 3
  - MOV reg / MVN: 5
  - CMP: 5
  - ADD / AND: 6
  - illegal: 2
- s while not in S_WAIT is ignored and not queued.
- s held high continuously: w is 1 for exactly one cycle between instructions (back-to-back issue).
- Unreachable state encodings -> S_WAIT.
- write, loada, loadb, loadc and loads are mutually exclusive and never high in S_WAIT or S_DECODE.

Decomposition:
- cpu_ctrl_pkg holds:
  - state enum (S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_REG)
  - OPC_MOV=3'b110, OPC_ALU=3'b101
  - op codes: ADD=00, CMP=01, AND=10, MVN=11, MOV_IMM=10, MOV_REG=00
  - NSEL_RN/RD/RM and VSEL_C/PC/IMM8/MDATA one-hot constants
- Sub-module cpu_ctrl_outdec: pure combinational state+fields -> control-word decoder. The parent holds the state register, the field latch and the next-state logic.

Test Plan:
- Reset mid-instruction: assert reset_n=0 while in S_WR_REG with write=1 -> write=0 and w=1 before the next edge; after release, stays in S_WAIT while s=0.
- MOV imm: opcode=110, op=10, s=1 one cycle -> S_DECODE, then S_WR_IMM with nsel=100, vsel=0100, write=1; w=1 on the 3rd clock. Changing opcode to 101 after the first edge has no effect.
- ADD: opcode=101, op=00 -> loada (nsel=100), loadb (nsel=001), loadc with asel=0, write (nsel=010, vsel=0001) in successive cycles; w=1 after 6 clocks; loads never high.
- CMP then MVN back-to-back with s held high: CMP asserts loads=1 in S_EXEC with no write; w=1 for one cycle; MVN skips S_GET_A, asserts asel=1 in S_EXEC, then writes Rd.
- Illegal field 111/xx and 110/01: illegal=1 for one cycle in S_DECODE, no load/write strobes, w=1 on the 2nd clock.
- Ignored start: pulse s during S_GET_B of an AND -> no extra instruction; controller returns to S_WAIT and stays there.
